// File: rtl/control_unit_if.sv
// control_unit_if -- groups the signals between the control unit and the
// datapath.
//   IR[2:0]        opcode field of the instruction register (bits 7..5)
//   Aeq0, Apos     datapath flags: A == 0, A > 0 (signed)
//   Enter          operator strobe that completes an IN instruction
//   IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel[1:0]
//                  datapath controls
//   Halt           high while the machine is halted
//   State[3:0]     current FSM state code, for debug
// Modports: master = control unit side, slave = datapath side.
interface control_unit_if;
  logic [2:0] IR;
  logic       Aeq0;
  logic       Apos;
  logic       Enter;
  logic       IRload;
  logic       JMPmux;
  logic       PCload;
  logic       Meminst;
  logic       MemWr;
  logic       Aload;
  logic       Sub;
  logic [1:0] Asel;
  logic       Halt;
  logic [3:0] State;

  modport master (
    input  IR, Aeq0, Apos, Enter,
    output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
  );

  modport slave (
    output IR, Aeq0, Apos, Enter,
    input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
  );
endinterface

// File: rtl/control_unit.sv
// control_unit -- Moore FSM sequencing a simple accumulator CPU through
// fetch / decode / execute.
//   Clock   system clock, all state changes on the rising edge
//   Reset   synchronous active-high reset, forces START
//   bus     control_unit_if.master: opcode, flags and Enter in; datapath
//           controls, Halt and debug State out
// Every instruction takes FETCH + DECODE + one execute cycle, except IN
// (waits in INPUT for Enter) and HALT (held until Reset).
module control_unit (
  input  logic           Clock,
  input  logic           Reset,
  control_unit_if.master bus
);

  localparam logic [3:0] START  = 4'd0;
  localparam logic [3:0] FETCH  = 4'd1;
  localparam logic [3:0] DECODE = 4'd2;
  localparam logic [3:0] LOAD   = 4'd3;
  localparam logic [3:0] STORE  = 4'd4;
  localparam logic [3:0] ADD    = 4'd5;
  localparam logic [3:0] SUB    = 4'd6;
  localparam logic [3:0] INPUT  = 4'd7;
  localparam logic [3:0] JZ     = 4'd8;
  localparam logic [3:0] JPOS   = 4'd9;
  localparam logic [3:0] HALT   = 4'd10;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_RAM = 2'b10;

  logic [3:0] state_q;
  logic [3:0] state_d;

  logic       ir_load;
  logic       jmp_mux;
  logic       pc_load;
  logic       mem_inst;
  logic       mem_wr;
  logic       a_load;
  logic       sub;
  logic [1:0] a_sel;
  logic       halt;

  // Next-state logic
  always_comb begin
    state_d = START;
    case (state_q)
      START:  state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.IR)
          3'b000:  state_d = LOAD;
          3'b001:  state_d = STORE;
          3'b010:  state_d = ADD;
          3'b011:  state_d = SUB;
          3'b100:  state_d = INPUT;
          3'b101:  state_d = JZ;
          3'b110:  state_d = JPOS;
          default: state_d = HALT;
        endcase
      end
      LOAD, STORE, ADD, SUB, JZ, JPOS: state_d = FETCH;
      INPUT:   state_d = bus.Enter ? FETCH : INPUT;
      HALT:    state_d = HALT;
      // Codes 11..15 are unreachable in normal operation; recover via START.
      default: state_d = START;
    endcase
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= START;
    else       state_q <= state_d;
  end

  // Output decode: everything from the state, except the conditional
  // PCload in JZ/JPOS which also looks at the datapath flag.
  always_comb begin
    ir_load  = 1'b0;
    jmp_mux  = 1'b0;
    pc_load  = 1'b0;
    mem_inst = 1'b0;
    mem_wr   = 1'b0;
    a_load   = 1'b0;
    sub      = 1'b0;
    a_sel    = ASEL_ALU;
    halt     = 1'b0;
    case (state_q)
      FETCH: begin
        ir_load = 1'b1;
        pc_load = 1'b1;
      end
      DECODE: mem_inst = 1'b1;
      LOAD: begin
        mem_inst = 1'b1;
        a_sel    = ASEL_RAM;
        a_load   = 1'b1;
      end
      STORE: begin
        mem_inst = 1'b1;
        mem_wr   = 1'b1;
      end
      ADD: begin
        mem_inst = 1'b1;
        a_load   = 1'b1;
      end
      SUB: begin
        mem_inst = 1'b1;
        a_load   = 1'b1;
        sub      = 1'b1;
      end
      INPUT: begin
        a_sel  = ASEL_IN;
        a_load = 1'b1;
      end
      JZ: begin
        jmp_mux = 1'b1;
        pc_load = bus.Aeq0;
      end
      JPOS: begin
        jmp_mux = 1'b1;
        pc_load = bus.Apos;
      end
      HALT: halt = 1'b1;
      default: ;
    endcase
  end

  assign bus.IRload  = ir_load;
  assign bus.JMPmux  = jmp_mux;
  assign bus.PCload  = pc_load;
  assign bus.Meminst = mem_inst;
  assign bus.MemWr   = mem_wr;
  assign bus.Aload   = a_load;
  assign bus.Sub     = sub;
  assign bus.Asel    = a_sel;
  assign bus.Halt    = halt;
  assign bus.State   = state_q;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-003 SHALL have port IR, input, 3 bits: opcode field of the datapath instruction register (bits 7..5).
REQ-004 SHALL have ports Aeq0 and Apos, inputs, 1 bit each: datapath flags meaning A == 0 and A > 0 (signed).
REQ-005 SHALL have port Enter, input, 1 bit: operator strobe that completes an IN instruction.
REQ-006 SHALL have ports IRload, JMPmux, PCload, Meminst, MemWr, Aload and Sub, outputs, 1 bit each: datapath controls.
- JMPmux: 1 = PC source is IR address; 0 = PC+1.
- Meminst: 1 = RAM address is IR address; 0 = PC.
- Sub: 1 = adder/subtractor subtracts.
REQ-007 SHALL have port Asel, output, 2 bits: A-register source; 00 = add/sub result, 01 = Input, 10 = RAM data, 11 never driven.
REQ-008 SHALL have port Halt, output, 1 bit: 1 while in HALT.
REQ-009 SHALL have port State, output, 4 bits: current state code, for debug.

Function
REQ-010 SHALL be a Moore FSM; all outputs decode from the state register only; every control not listed for a state is 0.
REQ-011 SHALL use state codes START=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, ADD=5, SUB=6, INPUT=7, JZ=8, JPOS=9, HALT=10.
REQ-012 SHALL sequence state transitions as follows:
- START -> FETCH unconditionally.
- FETCH -> DECODE.
- DECODE -> execute state selected by IR as sampled in DECODE: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
REQ-013 SHALL return LOAD, STORE, ADD, SUB, JZ and JPOS to FETCH after exactly one cycle.
REQ-014 SHALL hold INPUT while Enter=0 and go INPUT -> FETCH on the first edge with Enter=1, so an IN instruction takes at least one cycle.
REQ-015 SHALL hold HALT until Reset, ignoring every other input.
REQ-016 SHALL send unused codes 11..15 to START on the next edge with all controls 0 and Halt=0.
REQ-017 SHALL drive, per state:
- FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0.
- DECODE: Meminst=1.
- LOAD: Meminst=1, Asel=10, Aload=1.
- STORE: Meminst=1, MemWr=1.
- ADD: Meminst=1, Asel=00, Aload=1, Sub=0.
- SUB: Meminst=1, Asel=00, Aload=1, Sub=1.
- INPUT: Asel=01, Aload=1.
- JZ: JMPmux=1, PCload=Aeq0.
- JPOS: JMPmux=1, PCload=Apos.
- HALT: Halt=1.
REQ-018 SHALL make JZ and JPOS the only states whose PCload depends on a datapath flag; this is the sole Mealy-like term, combinational from state and flag.
REQ-019 SHALL never assert MemWr and Aload in the same cycle, and never assert IRload outside FETCH.
REQ-020 SHALL give per-instruction latency FETCH+DECODE+1 = 3 cycles, except INPUT (>= 3) and HALT (terminal).

Reset
REQ-021 SHALL, on any edge with Reset=1, enter START regardless of current state, including mid-instruction and HALT.
REQ-022 SHALL, in START, drive every output 0 and State=0; PC and A clearing are the datapath's responsibility.
REQ-023 SHALL, when Reset is deasserted, be in FETCH on the next edge.

Verification
REQ-024 SHALL cover reset then run: Reset=1 for 2 edges, then 0 -> State 0, then 1, then 2; IRload=1 and PCload=1 only in the FETCH cycle.
REQ-025 SHALL cover LOAD then ADD: IR=000 then IR=010 -> State sequence 1,2,3,1,2,5,1; Asel=10 in state 3, Asel=00 with Sub=0 in state 5, Aload=1 in both.
REQ-026 SHALL cover STORE and SUB: IR=001 -> MemWr=1 for exactly one cycle with Meminst=1 and Aload=0; IR=011 -> Sub=1 with Aload=1 for one cycle.
REQ-027 SHALL cover jumps: JZ with Aeq0=1 -> PCload=1 and JMPmux=1; JZ with Aeq0=0 -> PCload=0; JPOS with Apos=1 -> PCload=1.
REQ-028 SHALL cover INPUT wait: IR=100, Enter=0 for 4 cycles -> State stays 7 with Aload=1; Enter=1 -> next State=1.
REQ-029 SHALL cover HALT and reset mid-operation: IR=111 -> Halt=1, State=10 held for 10 cycles; Reset=1 in HALT or in state 7 -> State=0, all outputs 0 next cycle.
